// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single data memory.
// Optional round-robin arbitration via DMEM_ARB_RR_EN.
`ifndef MEM_DEPTH
`define MEM_DEPTH 32'd4096
`endif

module dmem_arbiter #(
  parameter logic [31:0] START_ADDR  = 32'h01000000,
  parameter logic [31:0] DEPTH_BYTES = `MEM_DEPTH
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_rw,
  input  logic [31:0] req0_addr,
  input  logic [1:0]  req0_size,
  input  logic [31:0] req0_wdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_rw,
  input  logic [31:0] req1_addr,
  input  logic [1:0]  req1_size,
  input  logic [31:0] req1_wdata,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,
  output logic        mem_read_write,
  output logic [31:0] mem_address,
  output logic [1:0]  mem_access_size,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        rw_q, rw_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic        port_q, port_d;
  logic        err_q, err_d;
`ifdef DMEM_ARB_RR_EN
  logic        last_grant_q, last_grant_d;
`endif

  logic        gnt0, gnt1;
  logic        sel_rw;
  logic [31:0] sel_addr;
  logic [1:0]  sel_size;
  logic [31:0] sel_wdata;
  logic [32:0] sel_end;
  logic        sel_oor;
  logic [31:0] rdata;

  // Grant one valid port while idle; reset forces no grant.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE && reset_n) begin
`ifdef DMEM_ARB_RR_EN
      if (req0_valid && (!req1_valid || last_grant_q))
        gnt0 = 1'b1;
      else if (req1_valid)
        gnt1 = 1'b1;
`else
      if (req0_valid)
        gnt0 = 1'b1;
      else if (req1_valid)
        gnt1 = 1'b1;
`endif
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Mux the granted request and check it against the memory window.
  always_comb begin
    sel_rw    = gnt1 ? req1_rw    : req0_rw;
    sel_addr  = gnt1 ? req1_addr  : req0_addr;
    sel_size  = gnt1 ? req1_size  : req0_size;
    sel_wdata = gnt1 ? req1_wdata : req0_wdata;
    sel_end   = {1'b0, sel_addr - START_ADDR}
              + (33'd1 << sel_size);
    sel_oor   = (sel_addr < START_ADDR)
             || (sel_end > {1'b0, DEPTH_BYTES})
             || (sel_size == 2'd3);
  end

  // Next state and request capture.
  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    port_d  = port_q;
    err_d   = err_q;
`ifdef DMEM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          state_d = ISSUE;
          rw_d    = sel_rw;
          addr_d  = sel_addr;
          size_d  = sel_size;
          wdata_d = sel_wdata;
          port_d  = gnt1;
          err_d   = sel_oor;
`ifdef DMEM_ARB_RR_EN
          last_grant_d = gnt1;
`endif
        end
      end
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and captured-request registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      port_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      port_q  <= port_d;
      err_q   <= err_d;
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Remember the last granted port for fairness.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      last_grant_q <= 1'b1;
    else
      last_grant_q <= last_grant_d;
  end
`endif

  // Captured regs only change on accept, so they hold outside ISSUE.
  assign mem_read_write  = (state_q == ISSUE) && rw_q && !err_q;
  assign mem_address     = addr_q;
  assign mem_access_size = size_q;
  assign mem_data_in     = wdata_q;

  // Size-masked read data for in-range reads only.
  always_comb begin
    rdata = '0;
    if (state_q == RESP && !rw_q && !err_q) begin
      unique case (size_q)
        2'd0:    rdata = mem_data_out & 32'h000000FF;
        2'd1:    rdata = mem_data_out & 32'h0000FFFF;
        default: rdata = mem_data_out;
      endcase
    end
  end

  assign rsp0_valid = (state_q == RESP) && !port_q;
  assign rsp1_valid = (state_q == RESP) && port_q;
  assign rsp0_rdata = rsp0_valid ? rdata : 32'd0;
  assign rsp1_rdata = rsp1_valid ? rdata : 32'd0;
  assign rsp0_err   = rsp0_valid && err_q;
  assign rsp1_err   = rsp1_valid && err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors plus reset/arbitration sequences
// against a behavioural byte memory.
module tb_dmem_arbiter;

  localparam logic [31:0] SA = 32'h01000000;
  localparam logic [31:0] DB = 32'd4096;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req0_valid, req0_ready, req0_rw;
  logic [31:0] req0_addr, req0_wdata;
  logic [1:0]  req0_size;
  logic        req1_valid, req1_ready, req1_rw;
  logic [31:0] req1_addr, req1_wdata;
  logic [1:0]  req1_size;
  logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        mem_read_write;
  logic [31:0] mem_address, mem_data_in;
  logic [1:0]  mem_access_size;
  logic [31:0] mem_data_out;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  dmem_arbiter #(.START_ADDR(SA), .DEPTH_BYTES(DB)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_rw(req0_rw), .req0_addr(req0_addr),
    .req0_size(req0_size), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_rw(req1_rw), .req1_addr(req1_addr),
    .req1_size(req1_size), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .rsp1_err(rsp1_err),
    .mem_read_write(mem_read_write), .mem_address(mem_address),
    .mem_access_size(mem_access_size), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  // Byte memory; reads rotate so the addressed byte lands in bits 7:0.
  logic [7:0] mem [0:4095];
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem_data_out = 32'd0;
  end
  always @(posedge clock) begin
    logic [11:0] o;
    o = 12'(mem_address - SA);
    if (mem_read_write)
      for (int i = 0; i < (1 << mem_access_size); i++)
        mem[12'(o + i)] <= mem_data_in[8*i +: 8];
    mem_data_out <= {mem[12'(o + 3)], mem[12'(o + 2)],
                     mem[12'(o + 1)], mem[o]};
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       nm;
    logic        port;
    logic        rw;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  task automatic drive(input logic p, input logic rw,
                       input logic [31:0] a, input logic [1:0] s,
                       input logic [31:0] w);
    if (!p) begin
      req0_valid = 1'b1; req0_rw = rw; req0_addr = a;
      req0_size = s; req0_wdata = w;
    end else begin
      req1_valid = 1'b1; req1_rw = rw; req1_addr = a;
      req1_size = s; req1_wdata = w;
    end
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clock);
    drive(v.port, v.rw, v.addr, v.size, v.wdata);
    #1;
    chk({v.nm, "_ready"}, v.port ? req1_ready : req0_ready, 1);
    chk({v.nm, "_oth_ready"}, v.port ? req0_ready : req1_ready, 0);
    @(negedge clock);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk({v.nm, "_issue_wr"}, mem_read_write, v.rw && !v.err);
    chk({v.nm, "_issue_rsp"}, rsp0_valid | rsp1_valid, 0);
    @(negedge clock);
    chk({v.nm, "_mem_wr_resp"}, mem_read_write, 0);
    chk({v.nm, "_rsp_valid"}, v.port ? rsp1_valid : rsp0_valid, 1);
    chk({v.nm, "_oth_valid"}, v.port ? rsp0_valid : rsp1_valid, 0);
    chk({v.nm, "_rdata"}, v.port ? rsp1_rdata : rsp0_rdata, v.rdata);
    chk({v.nm, "_err"}, v.port ? rsp1_err : rsp0_err, v.err);
  endtask

  vec_t vecs[12];
  logic exp_g[4];

  initial begin
    vecs[0]  = '{"wr_word", 0, 1, SA + 32'h10, 2, 32'hDEADBEEF, 0, 0};
    vecs[1]  = '{"rd_word", 0, 0, SA + 32'h10, 2, 0, 32'hDEADBEEF, 0};
    vecs[2]  = '{"rd_byte_p1", 1, 0, SA + 32'h13, 0, 0, 32'hDE, 0};
    vecs[3]  = '{"rd_half_mis", 1, 0, SA + 32'h11, 1, 0, 32'hADBE, 0};
    vecs[4]  = '{"err_below", 0, 0, 32'h00FFFFFC, 2, 0, 0, 1};
    vecs[5]  = '{"err_top", 0, 0, SA + DB - 2, 2, 0, 0, 1};
    vecs[6]  = '{"top_half_ok", 0, 0, SA + DB - 2, 1, 0, 0, 0};
    vecs[7]  = '{"wr_top_byte", 1, 1, SA + DB - 1, 0, 32'hAB55, 0, 0};
    vecs[8]  = '{"rd_top_byte", 1, 0, SA + DB - 1, 0, 0, 32'h55, 0};
    vecs[9]  = '{"err_size3", 0, 0, SA + 32'h10, 3, 0, 0, 1};
    vecs[10] = '{"err_wr_past", 1, 1, SA + DB, 2, 32'h12345678, 0, 1};
    vecs[11] = '{"wr_half", 0, 1, SA + 32'h20, 1, 32'hCAFE1234, 0, 0};
`ifdef DMEM_ARB_RR_EN
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

    reset_n = 1'b0;
    req0_valid = 1'b1; req0_rw = 1'b1; req0_addr = SA;
    req0_size = 2'd2; req0_wdata = 32'hFFFFFFFF;
    req1_valid = 1'b0; req1_rw = 1'b0; req1_addr = 32'd0;
    req1_size = 2'd0; req1_wdata = 32'd0;
    #22;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_mem_rw", mem_read_write, 0);
    chk("rst_mem_addr", mem_address, 0);
    chk("rst_mem_din", mem_data_in, 0);
    chk("rst_rsp", {30'd0, rsp0_valid, rsp1_valid}, 0);
    req0_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);
    run_vec('{"rd_half_word", 0, 0, SA + 32'h20, 2, 0,
              32'h00001234, 0});

    // Reset during ISSUE of a write: dropped, no response.
    @(negedge clock);
    drive(0, 1, SA + 32'h10, 2, 32'h11111111);
    #1;
    chk("rstw_ready", req0_ready, 1);
    @(negedge clock);
    req0_valid = 1'b0;
    chk("rstw_issue_wr", mem_read_write, 1);
    reset_n = 1'b0;
    #1;
    chk("rstw_mem_rw", mem_read_write, 0);
    chk("rstw_mem_addr", mem_address, 0);
    chk("rstw_mem_din", mem_data_in, 0);
    chk("rstw_mem_size", {30'd0, mem_access_size}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("rstw_no_rsp", {29'd0, rsp0_valid, rsp1_valid,
                          mem_read_write}, 0);
    end

    // Both ports held valid for four accepts.
    @(negedge clock);
    drive(0, 0, SA + 32'h10, 2, 0);
    drive(1, 0, SA + 32'h13, 0, 0);
    for (int k = 0; k < 4; k++) begin
      bit got;
      got = 1'b0;
      for (int c = 0; c < 6; c++) begin
        #1;
        if (req0_ready || req1_ready) begin
          got = 1'b1;
          break;
        end
        @(negedge clock);
      end
      if (!got) chk("arb_timeout", 0, 1);
      else begin
        chk("arb_one_hot", req0_ready & req1_ready, 0);
        chk($sformatf("arb_grant%0d", k), req1_ready, exp_g[k]);
      end
      @(negedge clock);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clock);

    run_vec('{"rd_after_rst", 0, 0, SA + 32'h10, 2, 0,
              32'hDEADBEEF, 0});

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
